// File: rtl/redundancy_pair_scheduler.sv
`default_nettype none
//==============================================================================
// Module   : redundancy_pair_scheduler
// Brief    : Buffers redundant operand-index pairs, orders each pair so that
//            idx1 < idx2, feeds them to the DistanceCalculator with a stable
//            layer configuration, and returns the calculator's valid results
//            as a valid/ready stream with a per-layer done pulse.
// Options  : `define REDUNDANCY_SCHED_STAT_EN adds the stat_issued and
//            stat_dropped saturating counters.
// Revision : 1.0 - initial release
//==============================================================================
module redundancy_pair_scheduler #(
    parameter int WORD_WIDTH = 8,
    parameter int DIST_WIDTH = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [WORD_WIDTH-1:0] cfg_ld,
    input  logic [WORD_WIDTH-1:0] cfg_ow,
    input  logic [WORD_WIDTH-1:0] cfg_fw,
    input  logic [WORD_WIDTH-1:0] cfg_st,
    input  logic                  start,
    output logic                  cfg_err,
    input  logic                  pair_valid,
    output logic                  pair_ready,
    input  logic [WORD_WIDTH-1:0] pair_idx_a,
    input  logic [WORD_WIDTH-1:0] pair_idx_b,
    input  logic                  pair_last,
    output logic [WORD_WIDTH-1:0] dc_idx1,
    output logic [WORD_WIDTH-1:0] dc_idx2,
    output logic [WORD_WIDTH-1:0] dc_ld,
    output logic [WORD_WIDTH-1:0] dc_ow,
    output logic [WORD_WIDTH-1:0] dc_fw,
    output logic [WORD_WIDTH-1:0] dc_st,
    input  logic                  dc_valid,
    input  logic [DIST_WIDTH-1:0] dc_dr,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WORD_WIDTH-1:0] res_idx1,
    output logic [WORD_WIDTH-1:0] res_idx2,
    output logic [DIST_WIDTH-1:0] res_dr,
    output logic                  busy,
`ifdef REDUNDANCY_SCHED_STAT_EN
    output logic [WORD_WIDTH-1:0] stat_issued,
    output logic [WORD_WIDTH-1:0] stat_dropped,
`endif
    output logic                  done
);

    localparam int                c_ADDR_W   = $clog2(FIFO_DEPTH);
    localparam logic [c_ADDR_W:0] c_FULL_CNT = (c_ADDR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Layer configuration, frozen outside IDLE
    logic [WORD_WIDTH-1:0] r_ld;
    logic [WORD_WIDTH-1:0] r_ow;
    logic [WORD_WIDTH-1:0] r_fw;
    logic [WORD_WIDTH-1:0] r_st;
    logic                  r_cfg_err;

    // Pair FIFO; entries are stored already ordered as {max, min}
    logic [2*WORD_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0]     r_wr_ptr;
    logic [c_ADDR_W-1:0]     r_rd_ptr;
    logic [c_ADDR_W:0]       r_count;

    // Issue stage drives the calculator
    logic                  r_iss_v;
    logic [WORD_WIDTH-1:0] r_iss_idx1;
    logic [WORD_WIDTH-1:0] r_iss_idx2;

    // Result stage holds the output beat until it is consumed
    logic                  r_res_v;
    logic [WORD_WIDTH-1:0] r_res_idx1;
    logic [WORD_WIDTH-1:0] r_res_idx2;
    logic [DIST_WIDTH-1:0] r_res_dr;

    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic                  w_adv;
    logic                  w_iss_open;
    logic                  w_pop;
    logic                  w_pair_ready;
    logic                  w_accept;
    logic                  w_same;
    logic                  w_push;
    logic [WORD_WIDTH-1:0] w_lo;
    logic [WORD_WIDTH-1:0] w_hi;
    logic                  w_cfg_ok;
    logic                  w_in_idle;
    logic                  w_start_ok;
    logic                  w_start_bad;
    logic                  w_pipe_empty;
    logic                  w_busy;
    logic                  w_done;

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == c_FULL_CNT);
    // The issue entry retires whenever the result slot is free or draining
    assign w_adv        = r_iss_v && (!r_res_v || res_ready);
    assign w_iss_open   = !r_iss_v || w_adv;
    assign w_pop        = w_iss_open && !w_fifo_empty;
    assign w_accept     = pair_valid && w_pair_ready;
    assign w_same       = (pair_idx_a == pair_idx_b);
    // Equal-index pairs carry no work: accepted but never written
    assign w_push       = w_accept && !w_same;
    assign w_lo         = (pair_idx_a < pair_idx_b) ? pair_idx_a : pair_idx_b;
    assign w_hi         = (pair_idx_a < pair_idx_b) ? pair_idx_b : pair_idx_a;
    // Start is judged on the registered config, not a same-cycle write
    assign w_cfg_ok     = (r_fw != '0) && (r_st != '0);
    assign w_in_idle    = (r_state == ST_IDLE);
    assign w_start_ok   = w_in_idle && start && w_cfg_ok;
    assign w_start_bad  = w_in_idle && start && !w_cfg_ok;
    assign w_pipe_empty = w_fifo_empty && !r_iss_v && !r_res_v;

    // Next-state and state-derived outputs
    always_comb begin
        w_state_next = r_state;
        w_pair_ready = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (w_start_ok) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // A pop in the same cycle frees a slot for a full FIFO
                w_pair_ready = !w_fifo_full || w_pop;
                if (pair_valid && w_pair_ready && pair_last) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pipe_empty) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register and start-rejection pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cfg_err <= w_start_bad;
        end
    end

    // Configuration registers, writable only while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ld <= '0;
            r_ow <= '0;
            r_fw <= '0;
            r_st <= '0;
        end else if (w_in_idle && cfg_we) begin
            r_ld <= cfg_ld;
            r_ow <= cfg_ow;
            r_fw <= cfg_fw;
            r_st <= cfg_st;
        end
    end

    // FIFO storage; contents need no reset since occupancy is tracked
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_hi, w_lo};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue stage: refill from the FIFO head whenever the slot opens
    always_ff @(posedge clk) begin
        if (reset) begin
            r_iss_v    <= 1'b0;
            r_iss_idx1 <= '0;
            r_iss_idx2 <= '0;
        end else if (w_iss_open) begin
            r_iss_v <= !w_fifo_empty;
            if (w_pop) begin
                {r_iss_idx2, r_iss_idx1} <= r_mem[r_rd_ptr];
            end
        end
    end

    // Result stage: capture calculator output, hold until consumed
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_v    <= 1'b0;
            r_res_idx1 <= '0;
            r_res_idx2 <= '0;
            r_res_dr   <= '0;
        end else if (w_adv && dc_valid) begin
            r_res_v    <= 1'b1;
            r_res_idx1 <= r_iss_idx1;
            r_res_idx2 <= r_iss_idx2;
            r_res_dr   <= dc_dr;
        end else if (res_ready) begin
            r_res_v <= 1'b0;
        end
    end

`ifdef REDUNDANCY_SCHED_STAT_EN
    logic [WORD_WIDTH-1:0] r_stat_issued;
    logic [WORD_WIDTH-1:0] r_stat_dropped;
    logic [WORD_WIDTH:0]   w_issued_sum;
    logic [WORD_WIDTH:0]   w_dropped_sum;

    // One extra bit catches overflow for saturation
    assign w_issued_sum  = {1'b0, r_stat_issued} + (WORD_WIDTH+1)'(w_adv);
    assign w_dropped_sum = {1'b0, r_stat_dropped}
                         + (WORD_WIDTH+1)'(w_adv && !dc_valid)
                         + (WORD_WIDTH+1)'(w_accept && w_same);

    // Saturating statistics, cleared when a layer starts
    always_ff @(posedge clk) begin
        if (reset || w_start_ok) begin
            r_stat_issued  <= '0;
            r_stat_dropped <= '0;
        end else begin
            r_stat_issued  <= w_issued_sum[WORD_WIDTH]  ? '1 : w_issued_sum[WORD_WIDTH-1:0];
            r_stat_dropped <= w_dropped_sum[WORD_WIDTH] ? '1 : w_dropped_sum[WORD_WIDTH-1:0];
        end
    end

    assign stat_issued  = r_stat_issued;
    assign stat_dropped = r_stat_dropped;
`endif

    assign cfg_err    = r_cfg_err;
    assign pair_ready = w_pair_ready;
    assign busy       = w_busy;
    assign done       = w_done;
    assign dc_idx1    = r_iss_idx1;
    assign dc_idx2    = r_iss_idx2;
    assign dc_ld      = r_ld;
    assign dc_ow      = r_ow;
    assign dc_fw      = r_fw;
    assign dc_st      = r_st;
    assign res_valid  = r_res_v;
    assign res_idx1   = r_res_idx1;
    assign res_idx2   = r_res_idx2;
    assign res_dr     = r_res_dr;

endmodule
`default_nettype wire

// File: tb/tb_redundancy_pair_scheduler.sv
`default_nettype none
//==============================================================================
// Module   : tb_redundancy_pair_scheduler
// Brief    : Self-checking bench for redundancy_pair_scheduler. A calculator
//            stub answers the dc_* outputs; a transaction-level model queues
//            the expected results of every accepted pair.
// Revision : 1.0 - initial release
//==============================================================================
module tb_redundancy_pair_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [7:0] cfg_ld, cfg_ow, cfg_fw, cfg_st;
    logic       start;
    logic       cfg_err;
    logic       pair_valid;
    logic       pair_ready;
    logic [7:0] pair_idx_a, pair_idx_b;
    logic       pair_last;
    logic [7:0] dc_idx1, dc_idx2, dc_ld, dc_ow, dc_fw, dc_st;
    logic       dc_valid;
    logic [6:0] dc_dr;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_idx1, res_idx2;
    logic [6:0] res_dr;
    logic       busy;
    logic       done;
`ifdef REDUNDANCY_SCHED_STAT_EN
    logic [7:0] stat_issued, stat_dropped;
`endif

    always #5 clk = ~clk;

    redundancy_pair_scheduler #(
        .WORD_WIDTH(8),
        .DIST_WIDTH(7),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_ld(cfg_ld), .cfg_ow(cfg_ow), .cfg_fw(cfg_fw), .cfg_st(cfg_st),
        .start(start), .cfg_err(cfg_err),
        .pair_valid(pair_valid), .pair_ready(pair_ready),
        .pair_idx_a(pair_idx_a), .pair_idx_b(pair_idx_b), .pair_last(pair_last),
        .dc_idx1(dc_idx1), .dc_idx2(dc_idx2),
        .dc_ld(dc_ld), .dc_ow(dc_ow), .dc_fw(dc_fw), .dc_st(dc_st),
        .dc_valid(dc_valid), .dc_dr(dc_dr),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_idx1(res_idx1), .res_idx2(res_idx2), .res_dr(res_dr),
        .busy(busy),
`ifdef REDUNDANCY_SCHED_STAT_EN
        .stat_issued(stat_issued), .stat_dropped(stat_dropped),
`endif
        .done(done)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [22:0] exp_q[$];
    int          n_results = 0;
    int          m_issued = 0;
    int          m_dropped = 0;
    logic [7:0]  m_ld = 8'd0;
    logic [1:0]  vmode = 2'd0;
    bit          rand_bp = 1'b0;
    logic        prev_stall = 1'b0;
    logic [22:0] prev_res = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Calculator stub: validity rule selected by vmode
    function automatic logic calc_valid(input logic [7:0] i1, input logic [7:0] i2, input logic [1:0] mode);
        case (mode)
            2'd1:    return ((i1 ^ i2) & 8'd3) != 8'd0;
            2'd2:    return !(i1 == 8'd7 && i2 == 8'd9);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [6:0] calc_dr(input logic [7:0] i1, input logic [7:0] i2, input logic [7:0] ld);
        return 7'(i2 - i1 + ld);
    endfunction

    always_comb begin
        dc_valid = calc_valid(dc_idx1, dc_idx2, vmode);
        dc_dr    = calc_dr(dc_idx1, dc_idx2, dc_ld);
    end

    // Model of one accepted pair: order it, decide whether a result exists
    task automatic model_accept(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] lo, hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (lo == hi) begin
            m_dropped++;
        end else begin
            m_issued++;
            if (calc_valid(lo, hi, vmode)) exp_q.push_back({lo, hi, calc_dr(lo, hi, m_ld)});
            else m_dropped++;
        end
    endtask

    // Monitor: handshakes observed mid-cycle, results scored in order
    initial begin
        logic [22:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("res_hold_valid", 32'(res_valid), 32'd1);
                    check("res_hold_data", 32'({res_idx1, res_idx2, res_dr}), 32'(prev_res));
                end
                if (res_valid && res_ready) begin
                    n_results++;
                    if (exp_q.size() == 0) begin
                        check("res_spurious", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_data", 32'({res_idx1, res_idx2, res_dr}), 32'(e));
                    end
                end
                prev_stall = res_valid && !res_ready;
                prev_res   = {res_idx1, res_idx2, res_dr};
                if (pair_valid && pair_ready) model_accept(pair_idx_a, pair_idx_b);
            end
        end
    end

    // Random downstream backpressure when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [7:0] ld, input logic [7:0] ow, input logic [7:0] fw, input logic [7:0] st);
        cfg_we = 1'b1; cfg_ld = ld; cfg_ow = ow; cfg_fw = fw; cfg_st = st;
        tick();
        cfg_we = 1'b0;
        m_ld = ld;
    endtask

    task automatic start_layer(input logic expect_ok);
        m_issued  = 0;
        m_dropped = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'(expect_ok));
        check("start_cfg_err", 32'(cfg_err), 32'(!expect_ok));
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic last);
        bit got;
        got = 1'b0;
        pair_valid = 1'b1; pair_idx_a = a; pair_idx_b = b; pair_last = last;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (pair_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        pair_valid = 1'b0; pair_last = 1'b0;
        if (!got) check("pair_accept_timeout", 32'(got), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int w = 0; w < 500; w++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
        tick();
        check("after_done_busy", 32'(busy), 32'd0);
        check("after_done_pulse", 32'(done), 32'd0);
    endtask

    task automatic layer_end_checks();
        check("layer_leftover", 32'(exp_q.size()), 32'd0);
`ifdef REDUNDANCY_SCHED_STAT_EN
        check("stat_issued", 32'(stat_issued), 32'(m_issued));
        check("stat_dropped", 32'(stat_dropped), 32'(m_dropped));
`endif
    endtask

    initial begin
        int base;
        bit done_seen;
        int n;
        reset = 1'b1; cfg_we = 1'b0; cfg_ld = '0; cfg_ow = '0; cfg_fw = '0; cfg_st = '0;
        start = 1'b0; pair_valid = 1'b0; pair_idx_a = '0; pair_idx_b = '0; pair_last = 1'b0;
        res_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_pair_ready", 32'(pair_ready), 32'd0);
        check("rst_dc_fw", 32'(dc_fw), 32'd0);
        reset = 1'b0;
        tick();

        // Start with zero filter width is rejected
        configure(8'd0, 8'd8, 8'd0, 8'd1);
        start_layer(1'b0);
        check("err_pair_ready", 32'(pair_ready), 32'd0);
        tick();
        check("err_pulse_end", 32'(cfg_err), 32'd0);

        // Same-cycle write and start: start sees the old (invalid) config
        cfg_we = 1'b1; cfg_ld = 8'd0; cfg_ow = 8'd8; cfg_fw = 8'd3; cfg_st = 8'd1; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0; m_ld = 8'd0;
        check("same_cycle_err", 32'(cfg_err), 32'd1);
        check("same_cycle_busy", 32'(busy), 32'd0);
        check("same_cycle_fw", 32'(dc_fw), 32'd3);
        tick();

        // Single pair, latency and ordering
        vmode = 2'd0;
        start_layer(1'b1);
        check("run_pair_ready", 32'(pair_ready), 32'd1);
        cfg_we = 1'b1; cfg_ld = 8'd9; cfg_ow = 8'd9; cfg_fw = 8'd9; cfg_st = 8'd9;
        tick();
        cfg_we = 1'b0;
        check("cfg_frozen", 32'({dc_ld, dc_ow, dc_fw, dc_st}), 32'h00080301);
        res_ready = 1'b1;
        send_pair(8'd5, 8'd2, 1'b1);
        check("lat_t0_res_valid", 32'(res_valid), 32'd0);
        tick();
        check("lat_t1_dc_idx", 32'({dc_idx1, dc_idx2}), 32'h0205);
        check("lat_t1_res_valid", 32'(res_valid), 32'd0);
        tick();
        check("lat_t2_res_valid", 32'(res_valid), 32'd1);
        check("lat_t2_res", 32'({res_idx1, res_idx2, res_dr}), 32'({8'd2, 8'd5, 7'd3}));
        wait_done("single_done");
        layer_end_checks();

        // Backpressure: capacity is FIFO plus issue and result stages
        start_layer(1'b1);
        res_ready = 1'b0;
        base = n_results;
        for (int i = 0; i < 6; i++) send_pair(8'(i + 1), 8'(20 - i), 1'b0);
        check("cap_full_ready", 32'(pair_ready), 32'd0);
        tick();
        tick();
        check("cap_still_full", 32'(pair_ready), 32'd0);
        check("cap_no_results", 32'(n_results - base), 32'd0);
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("b2b_valid", 32'(res_valid), 32'd1);
        end
        tick();
        check("b2b_count", 32'(n_results - base), 32'd6);
        send_pair(8'd4, 8'd4, 1'b1);
        check("eq_last_drain_busy", 32'(busy), 32'd1);
        check("eq_last_no_done", 32'(done), 32'd0);
        tick();
        check("eq_last_done", 32'(done), 32'd1);
        tick();
        check("eq_last_idle_busy", 32'(busy), 32'd0);
        check("eq_last_done_end", 32'(done), 32'd0);
        check("eq_last_no_result", 32'(n_results - base), 32'd6);
        layer_end_checks();

        // Calculator rejects the second of three pairs
        vmode = 2'd2;
        start_layer(1'b1);
        base = n_results;
        send_pair(8'd1, 8'd3, 1'b0);
        send_pair(8'd9, 8'd7, 1'b0);
        send_pair(8'd2, 8'd6, 1'b1);
        wait_done("invalid_done");
        check("invalid_count", 32'(n_results - base), 32'd2);
        layer_end_checks();

        // Reset in the middle of a layer
        vmode = 2'd0;
        start_layer(1'b1);
        res_ready = 1'b0;
        send_pair(8'd1, 8'd2, 1'b0);
        send_pair(8'd3, 8'd4, 1'b0);
        send_pair(8'd5, 8'd6, 1'b0);
        reset = 1'b1;
        tick();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_res", 32'({res_idx1, res_idx2, res_dr}), 32'd0);
        check("mid_rst_dc", 32'({dc_idx1, dc_idx2, dc_ld, dc_fw}), 32'd0);
        check("mid_rst_pair_ready", 32'(pair_ready), 32'd0);
        check("mid_rst_cfg_err", 32'(cfg_err), 32'd0);
`ifdef REDUNDANCY_SCHED_STAT_EN
        check("mid_rst_stats", 32'({stat_issued, stat_dropped}), 32'd0);
`endif
        reset = 1'b0;
        exp_q.delete();
        done_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || res_valid) done_seen = 1'b1;
        end
        tick();
        check("mid_rst_quiet", 32'(done_seen), 32'd0);
        configure(8'd2, 8'd8, 8'd3, 8'd2);
        start_layer(1'b1);
        res_ready = 1'b1;
        base = n_results;
        send_pair(8'd3, 8'd1, 1'b1);
        wait_done("post_rst_done");
        check("post_rst_count", 32'(n_results - base), 32'd1);
        layer_end_checks();

        // Randomised layers with random backpressure and gaps
        for (int layer = 0; layer < 4; layer++) begin
            vmode = (layer % 2 == 1) ? 2'd1 : 2'd0;
            configure(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
            start_layer(1'b1);
            rand_bp = 1'b1;
            n = $urandom_range(8, 24);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_pair(8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), i == n - 1);
            end
            wait_done("rand_done");
            rand_bp = 1'b0;
            res_ready = 1'b1;
            layer_end_checks();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
